// File: rtl/misc_wb_pkg.sv
// Shared widths, flag bit positions and the queue entry type for the
// misc-unit writeback queue.
package misc_wb_pkg;

  localparam int FLAG_W = 5;
  localparam int ZERO_B = 0;
  localparam int SIGN_B = 1;
  localparam int OVR_B  = 2;
  localparam int COUT_B = 3;
  localparam int NAN_B  = 4;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 128;
  localparam int SR_W   = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  dst;
    logic [SR_W-1:0]   sr;
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/misc_wb_queue_fifo.sv
// Synchronous FIFO of writeback entries. Push is never refused because the
// caller's credit scheme guarantees space, even when full with a same-edge pop.
module wb_fifo
  import misc_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  wb_entry_t  din,
  input  logic       pop,
  output wb_entry_t  dout,
  output logic       not_empty,
  output logic [4:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       level_reg;
  logic             do_pop;

  assign do_pop    = pop & (level_reg != 5'd0);
  assign not_empty = (level_reg != 5'd0);
  assign level     = level_reg;
  assign dout      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_reg <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   level_reg <= level_reg + 5'd1;
        2'b01:   level_reg <= level_reg - 5'd1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/misc_wb_queue.sv
// Writeback queue behind the misc execution unit: re-times the early tag to
// the late result, buffers entries, and issues credit-based BUSY upstream.
module misc_wb_queue
  import misc_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          ACT_IN,
  input  logic [3:0]    DST_IN,
  input  logic [127:0]  R_IN,
  input  logic          ZERO_IN,
  input  logic          SIGN_IN,
  input  logic          OVR_IN,
  input  logic          COUT_IN,
  input  logic          NAN_IN,
  input  logic [2:0]    SR_IN,
  output logic          BUSY,
  output logic          WB_VALID,
  input  logic          WB_READY,
  output logic [3:0]    WB_DST,
  output logic [127:0]  WB_DATA,
  output logic [4:0]    WB_FLAGS,
  output logic [2:0]    WB_SR,
  output logic [4:0]    LEVEL,
  output logic          ERR
);

  logic [LAT-1:0]   tag_valid;
  logic [TAG_W-1:0] tag_dst [LAT];
  logic [2:0]       inflight;
  logic [5:0]       credit;
  logic [4:0]       level;
  logic             err_reg;
  logic [FLAG_W-1:0] flags_in;
  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic             head_valid;

  // A rejected issue still shifts in a bubble so its late result is ignored.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tag_valid <= '0;
      for (int i = 0; i < LAT; i++) tag_dst[i] <= '0;
    end else begin
      tag_valid[0] <= ACT_IN & ~BUSY;
      tag_dst[0]   <= DST_IN;
      for (int i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_dst[i]   <= tag_dst[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + 3'(tag_valid[i]);
  end

  // Credit counts both stored and promised entries; registered state only.
  assign credit = {1'b0, level} + {3'b000, inflight};
  assign BUSY   = (credit >= 6'(DEPTH));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) err_reg <= 1'b0;
    else         err_reg <= err_reg | (ACT_IN & BUSY);
  end

  assign ERR = err_reg;

  always_comb begin
    flags_in         = '0;
    flags_in[ZERO_B] = ZERO_IN;
    flags_in[SIGN_B] = SIGN_IN;
    flags_in[OVR_B]  = OVR_IN;
    flags_in[COUT_B] = COUT_IN;
    flags_in[NAN_B]  = NAN_IN;
  end

  always_comb begin
    push_entry       = '0;
    push_entry.dst   = tag_dst[LAT-1];
    push_entry.sr    = SR_IN;
    push_entry.flags = flags_in;
    push_entry.data  = R_IN;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (tag_valid[LAT-1]),
    .din       (push_entry),
    .pop       (WB_READY),
    .dout      (head),
    .not_empty (head_valid),
    .level     (level)
  );

  assign WB_VALID = head_valid;
  assign WB_DST   = head.dst;
  assign WB_DATA  = head.data;
  assign WB_FLAGS = head.flags;
  assign WB_SR    = head.sr;
  assign LEVEL    = level;

endmodule

// File: tb/tb_misc_wb_queue.sv
// Scoreboard bench: issues push expected entries, a negedge monitor checks
// every popped head against them in order.
module tb_misc_wb_queue;
  import misc_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic         CLK = 1'b0;
  logic         RESETn;
  logic         ACT_IN;
  logic [3:0]   DST_IN;
  logic [127:0] R_IN;
  logic         ZERO_IN, SIGN_IN, OVR_IN, COUT_IN, NAN_IN;
  logic [2:0]   SR_IN;
  logic         BUSY, WB_VALID, WB_READY, ERR;
  logic [3:0]   WB_DST;
  logic [127:0] WB_DATA;
  logic [4:0]   WB_FLAGS;
  logic [2:0]   WB_SR;
  logic [4:0]   LEVEL;

  always #5 CLK = ~CLK;

  misc_wb_queue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK(CLK), .RESETn(RESETn), .ACT_IN(ACT_IN), .DST_IN(DST_IN), .R_IN(R_IN),
    .ZERO_IN(ZERO_IN), .SIGN_IN(SIGN_IN), .OVR_IN(OVR_IN), .COUT_IN(COUT_IN),
    .NAN_IN(NAN_IN), .SR_IN(SR_IN), .BUSY(BUSY), .WB_VALID(WB_VALID),
    .WB_READY(WB_READY), .WB_DST(WB_DST), .WB_DATA(WB_DATA), .WB_FLAGS(WB_FLAGS),
    .WB_SR(WB_SR), .LEVEL(LEVEL), .ERR(ERR)
  );

  wb_entry_t sb[$];
  wb_entry_t res_at[int];
  wb_entry_t exp_e;
  int nxt;
  int checks;
  int errors;

  // Monitor: the head seen here with WB_READY high is popped on the next edge.
  always @(negedge CLK) begin
    if (RESETn === 1'b1 && WB_VALID === 1'b1 && WB_READY === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got dst=%0d data=%0h, required no entry", WB_DST, WB_DATA);
      end else begin
        exp_e = sb.pop_front();
        if (WB_DST !== exp_e.dst || WB_DATA !== exp_e.data ||
            WB_FLAGS !== exp_e.flags || WB_SR !== exp_e.sr) begin
          errors++;
          $display("FAIL pop_entry: got dst=%0d data=%0h flags=%b sr=%0d, required dst=%0d data=%0h flags=%b sr=%0d",
                   WB_DST, WB_DATA, WB_FLAGS, WB_SR, exp_e.dst, exp_e.data, exp_e.flags, exp_e.sr);
        end else begin
          $display("pop dst=%0d data=%0h flags=%b sr=%0d ok", WB_DST, WB_DATA, WB_FLAGS, WB_SR);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  // Drives the unit's result bus for the upcoming edge; junk when nothing is due.
  task automatic drive_res();
    wb_entry_t e;
    if (res_at.exists(nxt)) begin
      e = res_at[nxt];
    end else begin
      e.data  = {$urandom, $urandom, $urandom, $urandom};
      e.flags = 5'($urandom);
      e.sr    = 3'($urandom);
      e.dst   = '0;
    end
    R_IN    = e.data;
    ZERO_IN = e.flags[ZERO_B];
    SIGN_IN = e.flags[SIGN_B];
    OVR_IN  = e.flags[OVR_B];
    COUT_IN = e.flags[COUT_B];
    NAN_IN  = e.flags[NAN_B];
    SR_IN   = e.sr;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    nxt++;
    ACT_IN = 1'b0;
    DST_IN = '0;
    drive_res();
  endtask

  task automatic issue(input logic [3:0] dst, input logic [127:0] data,
                       input logic [4:0] flags, input logic [2:0] sr, input bit accepted);
    wb_entry_t e;
    e.dst = dst; e.sr = sr; e.flags = flags; e.data = data;
    ACT_IN = 1'b1;
    DST_IN = dst;
    res_at[nxt + LAT] = e;
    if (accepted) sb.push_back(e);
  endtask

  task automatic drain(input string name, input bit rnd);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      WB_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      c++;
    end
    WB_READY = 1'b0;
    check({name, "_drained"}, 128'(sb.size()), 128'd0);
    check({name, "_level0"}, 128'(LEVEL), 128'd0);
  endtask

  initial begin
    int issued;
    int c;
    checks = 0; errors = 0; nxt = 0;
    RESETn = 1'b0; ACT_IN = 1'b0; DST_IN = '0; WB_READY = 1'b0;
    R_IN = '0; ZERO_IN = 0; SIGN_IN = 0; OVR_IN = 0; COUT_IN = 0; NAN_IN = 0; SR_IN = '0;

    @(posedge CLK); #1;
    check("rst_busy", 128'(BUSY), 128'd0);
    check("rst_valid", 128'(WB_VALID), 128'd0);
    check("rst_level", 128'(LEVEL), 128'd0);
    check("rst_err", 128'(ERR), 128'd0);
    check("rst_data", WB_DATA, 128'd0);
    check("rst_dst_flags_sr", 128'({WB_DST, WB_FLAGS, WB_SR}), 128'd0);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    nxt = 0;
    drive_res();

    // Single op: issue at edge 0, capture at edge 2, pop at edge 3.
    issue(4'd5, 128'h1234, 5'b01010, 3'd3, 1'b1);
    step();
    check("single_valid_e0", 128'(WB_VALID), 128'd0);
    step();
    check("single_nobypass", 128'(WB_VALID), 128'd0);
    step();
    check("single_valid_e2", 128'(WB_VALID), 128'd1);
    check("single_dst", 128'(WB_DST), 128'd5);
    check("single_data", WB_DATA, 128'h1234);
    check("single_level", 128'(LEVEL), 128'd1);
    WB_READY = 1'b1;
    step();
    WB_READY = 1'b0;
    check("single_level_pop", 128'(LEVEL), 128'd0);

    // Fill with WB_READY low: BUSY after the fourth accepted issue.
    for (int t = 1; t <= 4; t++) begin
      issue(4'(t), {96'hDEAD_BEEF_0000_1111_CAFE_F00D, 32'(t)}, 5'(t * 3), 3'(t), 1'b1);
      step();
      check($sformatf("fill_busy_%0d", t), 128'(BUSY), (t == 4) ? 128'd1 : 128'd0);
    end
    step();
    check("fill_level_e4", 128'(LEVEL), 128'd3);
    step();
    check("fill_level_e5", 128'(LEVEL), 128'd4);
    check("fill_busy_full", 128'(BUSY), 128'd1);
    WB_READY = 1'b1;
    step();
    WB_READY = 1'b0;
    check("first_pop_level", 128'(LEVEL), 128'd3);
    check("first_pop_busy", 128'(BUSY), 128'd0);

    // Capture and pop on the same edge while at full credit.
    issue(4'd6, 128'h6666_0000_0000_0000_0000_0000_0000_0006, 5'b10001, 3'd6, 1'b1);
    step();
    check("simul_busy", 128'(BUSY), 128'd1);
    step();
    WB_READY = 1'b1;
    step();
    check("simul_level", 128'(LEVEL), 128'd3);
    check("simul_head", 128'(WB_DST), 128'd3);
    drain("simul", 1'b0);

    // Violation: issue while BUSY is dropped and flags ERR.
    check("err_before", 128'(ERR), 128'd0);
    for (int t = 7; t <= 10; t++) begin
      issue(4'(t), {32'(t), 96'h7777_8888_9999_AAAA_BBBB_CCCC}, 5'(t), 3'(t), 1'b1);
      step();
    end
    check("viol_busy", 128'(BUSY), 128'd1);
    issue(4'd11, 128'hBAD, 5'b11111, 3'd7, 1'b0);
    step();
    check("viol_err_set", 128'(ERR), 128'd1);
    step();
    step();
    check("viol_level", 128'(LEVEL), 128'd4);
    step();
    check("viol_err_sticky", 128'(ERR), 128'd1);
    drain("viol", 1'b0);

    // Reset mid-flight: two queued, two in the tag pipeline.
    for (int t = 1; t <= 4; t++) begin
      issue(4'(t), {32'hFEED_0000 | 32'(t), 96'h0}, 5'(t), 3'(t), 1'b1);
      step();
    end
    check("pre_rst_level", 128'(LEVEL), 128'd2);
    sb.delete();
    RESETn = 1'b0;
    #1;
    check("arst_valid", 128'(WB_VALID), 128'd0);
    check("arst_level", 128'(LEVEL), 128'd0);
    check("arst_busy", 128'(BUSY), 128'd0);
    check("arst_err", 128'(ERR), 128'd0);
    check("arst_data", WB_DATA, 128'd0);
    #2;
    RESETn = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("post_rst_level", 128'(LEVEL), 128'd0);
    check("post_rst_valid", 128'(WB_VALID), 128'd0);

    // Wrap: ten ops streamed with random WB_READY, issue gated by BUSY.
    issued = 0;
    c = 0;
    while (issued < 10 && c < 300) begin
      WB_READY = 1'($urandom_range(0, 1));
      if (BUSY == 1'b0) begin
        issue(4'(issued + 1),
              {32'hC0DE_0000 | 32'(issued), ~32'(issued), 32'h1234_5678 ^ 32'(issued), 32'(issued * 7)},
              5'(issued * 5), 3'(issued), 1'b1);
        issued++;
      end
      step();
      c++;
    end
    check("wrap_issued", 128'(issued), 128'd10);
    drain("wrap", 1'b1);
    check("wrap_err", 128'(ERR), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
